// File: rtl/combo_lock_pkg.sv
// Shared types and constants for the combination-lock core.
package combo_lock_pkg;

  typedef enum logic [2:0] {
    StEntry,
    StCheck,
    StFail,
    StOpen,
    StLockout
  } state_e;

  localparam int unsigned NumDigits      = 4;
  localparam logic [15:0] LockoutPattern = 16'hEEEE;

  // Thermometer mask: one enable per digit already entered.
  function automatic logic [3:0] digit_mask(input logic [2:0] cnt);
    logic [3:0] mask;
    mask = '0;
    for (int i = 0; i < NumDigits; i++) begin
      if (i < int'(cnt)) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/combo_lock_core_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stable-level debounce and rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync_q1, sync_q2;
  logic            level_q, level_dly_q, pulse_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1     <= 1'b0;
      sync_q2     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      pulse_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync_q1     <= raw;
      sync_q2     <= sync_q1;
      level_dly_q <= level_q;
      pulse_q     <= level_q & ~level_dly_q;
      if (sync_q2 == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        level_q <= sync_q2;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/combo_lock_core.sv
// Combination-lock FSM: digit entry, code check, fail/lockout timing and display outputs.
module combo_lock_core
  import combo_lock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned FAIL_CYCLES     = 50_000_000,
  parameter int unsigned LOCKOUT_CYCLES  = 500_000_000,
  parameter int unsigned MAX_TRIES       = 3,
  parameter logic [15:0] DEFAULT_CODE    = 16'h1234
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] swt,
  input  logic        btnC,
  input  logic        btnU,
  input  logic        btnL,
  input  logic        btnR,
  output logic [15:0] disp_val,
  output logic [3:0]  disp_en,
  output logic        unlocked,
  output logic        alarm,
  output logic [15:0] led
);

  localparam int unsigned MaxCycles = (LOCKOUT_CYCLES > FAIL_CYCLES) ? LOCKOUT_CYCLES : FAIL_CYCLES;
  localparam int unsigned TimerW    = $clog2(MaxCycles + 1);
  localparam logic [TimerW-1:0] FailLoad = TimerW'(FAIL_CYCLES - 1);
  localparam logic [TimerW-1:0] LockLoad = TimerW'(LOCKOUT_CYCLES - 1);

  logic [3:0] btn_raw, btn_pulse, btn_level_unused;
  logic       p_enter, p_clear, p_lock, p_store;

  assign btn_raw = {btnR, btnL, btnU, btnC};
  assign {p_store, p_lock, p_clear, p_enter} = btn_pulse;

  for (genvar b = 0; b < 4; b++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn_raw[b]),
      .level(btn_level_unused[b]),
      .pulse(btn_pulse[b])
    );
  end

  state_e            state_q, state_d;
  logic [15:0]       entry_q, entry_d, code_q, code_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [1:0]        fails_q, fails_d, fails_inc;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [15:0]       disp_val_d, led_d;
  logic [3:0]        disp_en_d;

  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    cnt_d     = cnt_q;
    fails_d   = fails_q;
    code_d    = code_q;
    timer_d   = timer_q;
    fails_inc = fails_q + 2'd1;
    case (state_q)
      StEntry: begin
        if (cnt_q == 3'(NumDigits)) begin
          state_d = StCheck;
        end else if (p_clear) begin
          entry_d = '0;
          cnt_d   = '0;
        end else if (p_enter) begin
          entry_d = {entry_q[11:0], swt[3:0]};
          cnt_d   = cnt_q + 3'd1;
        end
      end
      StCheck: begin
        if (entry_q == code_q) begin
          state_d = StOpen;
          fails_d = '0;
        end else begin
          fails_d = fails_inc;
          if (fails_inc == 2'(MAX_TRIES)) begin
            state_d = StLockout;
            timer_d = LockLoad;
          end else begin
            state_d = StFail;
            timer_d = FailLoad;
          end
        end
      end
      StFail, StLockout: begin
        if (timer_q == '0) begin
          state_d = StEntry;
          entry_d = '0;
          cnt_d   = '0;
          if (state_q == StLockout) fails_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StOpen: begin
        // Store and relock are independent; both may fire in one cycle.
        if (p_store) code_d = swt;
        if (p_lock) begin
          state_d = StEntry;
          entry_d = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = StEntry;
    endcase

    case (state_d)
      StOpen:    disp_val_d = code_d;
      StLockout: disp_val_d = LockoutPattern;
      default:   disp_val_d = entry_d;
    endcase
    disp_en_d = (state_d == StEntry || state_d == StCheck) ? digit_mask(cnt_d) : 4'hF;
    led_d     = {state_d == StOpen, state_d == StLockout, fails_d, 8'h00, disp_en_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StEntry;
      entry_q  <= '0;
      cnt_q    <= '0;
      fails_q  <= '0;
      code_q   <= DEFAULT_CODE;
      timer_q  <= '0;
      disp_val <= '0;
      disp_en  <= '0;
      unlocked <= 1'b0;
      alarm    <= 1'b0;
      led      <= '0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      cnt_q    <= cnt_d;
      fails_q  <= fails_d;
      code_q   <= code_d;
      timer_q  <= timer_d;
      disp_val <= disp_val_d;
      disp_en  <= disp_en_d;
      unlocked <= (state_d == StOpen);
      alarm    <= (state_d == StLockout);
      led      <= led_d;
    end
  end

endmodule

// File: tb/tb_combo_lock_core.sv
// Directed self-checking bench for combo_lock_core with short debounce/fail/lockout times.
module tb_combo_lock_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] swt;
  logic        btnC, btnU, btnL, btnR;
  logic [15:0] disp_val, led;
  logic [3:0]  disp_en;
  logic        unlocked, alarm;

  int n_checks = 0;
  int n_fail   = 0;

  combo_lock_core #(
    .DEBOUNCE_CYCLES(4),
    .FAIL_CYCLES    (8),
    .LOCKOUT_CYCLES (16),
    .MAX_TRIES      (3),
    .DEFAULT_CODE   (16'h1234)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .swt     (swt),
    .btnC    (btnC),
    .btnU    (btnU),
    .btnL    (btnL),
    .btnR    (btnR),
    .disp_val(disp_val),
    .disp_en (disp_en),
    .unlocked(unlocked),
    .alarm   (alarm),
    .led     (led)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       btnC = v;
      1:       btnU = v;
      2:       btnL = v;
      default: btnR = v;
    endcase
  endtask

  // Clean press: held 10 cycles, then released long enough to settle.
  task automatic press(input int b, input logic [15:0] sw);
    swt = sw;
    set_btn(b, 1'b1);
    wait_neg(10);
    set_btn(b, 1'b0);
    wait_neg(12);
  endtask

  task automatic enter_digits(input logic [15:0] c, input int n);
    for (int i = 0; i < n; i++) press(0, {12'h000, c[15-4*i -: 4]});
  endtask

  // Leaves btnC held; returns just after the edge where the check result lands.
  task automatic fourth_raw(input logic [3:0] d);
    swt  = {12'h000, d};
    btnC = 1'b1;
    wait_neg(10);
  endtask

  task automatic release_c();
    btnC = 1'b0;
    wait_neg(12);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    swt   = '0;
    btnC  = 1'b0;
    btnU  = 1'b0;
    btnL  = 1'b0;
    btnR  = 1'b0;
    wait_neg(3);
    check_eq("rst_disp_val", 32'(disp_val), 32'h0);
    check_eq("rst_disp_en", 32'(disp_en), 32'h0);
    check_eq("rst_led", 32'(led), 32'h0);
    check_eq("rst_unlocked", 32'(unlocked), 32'h0);
    check_eq("rst_alarm", 32'(alarm), 32'h0);
    rst_n = 1'b1;
    wait_neg(2);

    // Glitches of 1..3 cycles must not register a digit.
    for (int g = 1; g <= 3; g++) begin
      swt  = 16'h0009;
      btnC = 1'b1;
      wait_neg(g);
      btnC = 1'b0;
      wait_neg(10);
    end
    check_eq("glitch_none", 32'(disp_en), 32'h0);

    // Clean 20-cycle press: pulse at edge 7, digit registered at edge 8.
    swt  = 16'h0001;
    btnC = 1'b1;
    wait_neg(7);
    check_eq("pulse_lat7", 32'(disp_en), 32'h0);
    wait_neg(1);
    check_eq("digit1_en", 32'(disp_en), 32'h1);
    wait_neg(12);
    btnC = 1'b0;
    wait_neg(12);
    check_eq("single_pulse", 32'(disp_en), 32'h1);
    check_eq("digit1_val", 32'(disp_val), 32'h0001);
    press(0, 16'h0002);
    check_eq("digit2_en", 32'(disp_en), 32'h3);
    press(0, 16'h0003);
    check_eq("digit3_en", 32'(disp_en), 32'h7);
    check_eq("digit3_val", 32'(disp_val), 32'h0123);

    // Fourth digit: cnt=4 at edge 8, CHECK at 9, OPEN at 10.
    swt  = 16'h0004;
    btnC = 1'b1;
    wait_neg(8);
    check_eq("digit4_en", 32'(disp_en), 32'hF);
    check_eq("digit4_locked", 32'(unlocked), 32'h0);
    wait_neg(1);
    check_eq("check_locked", 32'(unlocked), 32'h0);
    wait_neg(1);
    check_eq("open_unlocked", 32'(unlocked), 32'h1);
    check_eq("open_val", 32'(disp_val), 32'h1234);
    check_eq("open_led", 32'(led), 32'h800F);
    release_c();

    // Code change, relock, reopen with the new code.
    press(3, 16'hBEEF);
    check_eq("store_val", 32'(disp_val), 32'hBEEF);
    check_eq("store_open", 32'(unlocked), 32'h1);
    press(2, 16'h0000);
    check_eq("relock_en", 32'(disp_en), 32'h0);
    check_eq("relock_unl", 32'(unlocked), 32'h0);
    check_eq("relock_val", 32'(disp_val), 32'h0);
    enter_digits(16'hBEEF, 4);
    check_eq("newcode_open", 32'(unlocked), 32'h1);
    check_eq("newcode_val", 32'(disp_val), 32'hBEEF);

    // Reset in OPEN after a code change.
    rst_n = 1'b0;
    #1;
    check_eq("rstopen_val", 32'(disp_val), 32'h0);
    check_eq("rstopen_led", 32'(led), 32'h0);
    check_eq("rstopen_unl", 32'(unlocked), 32'h0);
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(2);
    enter_digits(16'h1234, 4);
    check_eq("code_revert", 32'(unlocked), 32'h1);
    check_eq("code_revert_val", 32'(disp_val), 32'h1234);
    press(2, 16'h0000);

    // Two failures, each 8 cycles of FAIL.
    for (int k = 1; k <= 2; k++) begin
      enter_digits(16'h0000, 3);
      fourth_raw(4'h0);
      check_eq("fail_count", 32'(led[13:12]), 32'(k));
      check_eq("fail_en", 32'(disp_en), 32'hF);
      check_eq("fail_unl", 32'(unlocked), 32'h0);
      wait_neg(7);
      check_eq("fail_hold", 32'(disp_en), 32'hF);
      wait_neg(1);
      check_eq("fail_end", 32'(disp_en), 32'h0);
      check_eq("fail_keep", 32'(led[13:12]), 32'(k));
      release_c();
    end

    // Third failure: 16 cycles of lockout, presses ignored.
    enter_digits(16'h0000, 3);
    fourth_raw(4'h0);
    check_eq("lock_alarm", 32'(alarm), 32'h1);
    check_eq("lock_val", 32'(disp_val), 32'hEEEE);
    check_eq("lock_led", 32'(led), 32'h700F);
    btnC = 1'b0;
    swt  = 16'h5555;
    btnR = 1'b1;
    wait_neg(15);
    check_eq("lock_hold", 32'(alarm), 32'h1);
    check_eq("lock_hold_val", 32'(disp_val), 32'hEEEE);
    wait_neg(1);
    check_eq("lock_end", 32'(alarm), 32'h0);
    check_eq("lock_end_led", 32'(led), 32'h0);
    check_eq("lock_end_val", 32'(disp_val), 32'h0);
    btnR = 1'b0;
    wait_neg(12);
    enter_digits(16'h1234, 4);
    check_eq("post_lock_open", 32'(unlocked), 32'h1);
    check_eq("post_lock_code", 32'(disp_val), 32'h1234);
    press(2, 16'h0000);

    // Reset during lockout.
    enter_digits(16'h0000, 4);
    enter_digits(16'h0000, 4);
    enter_digits(16'h0000, 3);
    fourth_raw(4'h0);
    check_eq("lock2_alarm", 32'(alarm), 32'h1);
    wait_neg(3);
    btnC  = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rstlock_alarm", 32'(alarm), 32'h0);
    check_eq("rstlock_val", 32'(disp_val), 32'h0);
    check_eq("rstlock_en", 32'(disp_en), 32'h0);
    check_eq("rstlock_led", 32'(led), 32'h0);
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(2);
    enter_digits(16'h1234, 4);
    check_eq("rstlock_reopen", 32'(unlocked), 32'h1);
    press(2, 16'h0000);

    // Clear and enter in the same cycle: clear wins.
    enter_digits(16'h1200, 2);
    check_eq("pre_clear_en", 32'(disp_en), 32'h3);
    swt  = 16'h0009;
    btnU = 1'b1;
    btnC = 1'b1;
    wait_neg(10);
    check_eq("clear_en", 32'(disp_en), 32'h0);
    check_eq("clear_val", 32'(disp_val), 32'h0);
    btnU = 1'b0;
    btnC = 1'b0;
    wait_neg(12);
    enter_digits(16'h1234, 4);
    check_eq("clear_reopen", 32'(unlocked), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
